// File: rtl/injector_local_port_arbiter.sv
// injector_local_port_arbiter
// Round-robin arbiter that lets NUM_REQ packet injectors share one router
// Local input port. Each injector sees the usual Req/Gnt/Full handshake; the
// router sees a single requester carrying one registered head flit per grant.
// Optional build macro: ARB_PKT_COUNT_EN enables the 16-bit forwarded-packet
// counter on PktCount; without it PktCount is a constant 0.
// Legal configurations: NUM_REQ in 2..8 and IDX_W == $clog2(NUM_REQ).

module injector_local_port_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int IDX_W     = 2,
  parameter int dataWidth = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             ReqUp,
  input  logic [NUM_REQ*dataWidth-1:0]   PacketIn,
  output logic [NUM_REQ-1:0]             GntUp,
  output logic [NUM_REQ-1:0]             FullUp,
  output logic                           ReqDnStr,
  input  logic                           GntDnStr,
  input  logic                           DnStrFull,
  output logic [dataWidth-1:0]           PacketOut,
  output logic [15:0]                    PktCount
);

  // FSM encoding kept as plain constants so older tools and scripts that
  // decode the state register keep working.
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_GNT = 2'd1;
  localparam logic [1:0] ST_RELEASE  = 2'd2;

  // One extra bit so ptr + offset never overflows before the modulo fold.
  localparam logic [IDX_W:0]   NUM_REQ_EXT = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_REQ-1);

  logic [1:0]           state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     winner_q, winner_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 req_dn_q, req_dn_d;
  logic [dataWidth-1:0] pkt_q, pkt_d;

  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  logic [IDX_W:0]       cand_sum;
  logic [dataWidth-1:0] pick_pkt;
  logic [NUM_REQ-1:0]   winner_onehot;
  logic                 grant_fire;

  // The router grant only means something while we are waiting for it.
  assign grant_fire = (state_q == ST_WAIT_GNT) && GntDnStr;

  // Round-robin search: the candidate closest to ptr (in wrap-around order)
  // wins. Scanning from the farthest offset down lets the nearest hit
  // overwrite earlier ones, so no priority chain of flags is needed.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand_sum   = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      cand_sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (cand_sum >= NUM_REQ_EXT) begin
        cand_sum = cand_sum - NUM_REQ_EXT;
      end
      if (ReqUp[cand_sum[IDX_W-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_sum[IDX_W-1:0];
      end
    end
  end

  // Select the winning injector's packet slice out of the flattened bus.
  always_comb begin
    pick_pkt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        pick_pkt = PacketIn[i*dataWidth +: dataWidth];
      end
    end
  end

  // One-hot form of the latched winner, used for the upstream grant pulse.
  always_comb begin
    winner_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner_q == IDX_W'(i)) begin
        winner_onehot[i] = 1'b1;
      end
    end
  end

  // Back-pressure: everyone is full when the router is full; while a
  // transaction is in flight, everyone except the current winner is full.
  always_comb begin
    FullUp = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      FullUp[i] = DnStrFull | ((state_q != ST_IDLE) && (winner_q != IDX_W'(i)));
    end
  end

  // Next-state logic: arbitrate in IDLE, hold the request until the router
  // grants, then wait for the winner to drop its request before re-arbitrating.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    winner_d = winner_q;
    gnt_d    = '0;
    req_dn_d = req_dn_q;
    pkt_d    = pkt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid && !DnStrFull) begin
          winner_d = pick_idx;
          pkt_d    = pick_pkt;
          req_dn_d = 1'b1;
          state_d  = ST_WAIT_GNT;
        end
      end
      ST_WAIT_GNT: begin
        if (grant_fire) begin
          req_dn_d = 1'b0;
          gnt_d    = winner_onehot;
          ptr_d    = (winner_q == LAST_IDX) ? '0 : winner_q + IDX_W'(1);
          state_d  = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!ReqUp[winner_q]) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        req_dn_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight packet silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      winner_q <= '0;
      gnt_q    <= '0;
      req_dn_q <= 1'b0;
      pkt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      winner_q <= winner_d;
      gnt_q    <= gnt_d;
      req_dn_q <= req_dn_d;
      pkt_q    <= pkt_d;
    end
  end

  assign GntUp     = gnt_q;
  assign ReqDnStr  = req_dn_q;
  assign PacketOut = pkt_q;

`ifdef ARB_PKT_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Count packets handed to the router; free-running wrap at 16 bits.
  always_comb begin
    cnt_d = cnt_q;
    if (grant_fire) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter register, cleared with the rest of the arbiter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign PktCount = cnt_q;
`else
  assign PktCount = 16'd0;
`endif

endmodule

// File: tb/tb_injector_local_port_arbiter.sv
// tb_injector_local_port_arbiter
// Self-checking bench: expected grants (injector index + packet) are queued
// when requests are driven and compared when GntUp pulses. Injectors and the
// router are modelled inside the per-cycle tick task.

module tb_injector_local_port_arbiter;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;
  localparam int DW      = 32;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_up;
  logic [NUM_REQ*DW-1:0] packet_in;
  logic [NUM_REQ-1:0]    gnt_up;
  logic [NUM_REQ-1:0]    full_up;
  logic                  req_dn;
  logic                  gnt_dn;
  logic                  dn_full;
  logic [DW-1:0]         packet_out;
  logic [15:0]           pkt_count;

  typedef struct {
    int          idx;
    logic [31:0] pkt;
  } exp_t;

  exp_t               sb[$];
  int                 check_count = 0;
  int                 error_count = 0;
  logic [NUM_REQ-1:0] drop_next;
  logic [NUM_REQ-1:0] raise_next;
  logic [NUM_REQ-1:0] prev_gnt;
  int                 rereq[NUM_REQ];
  bit                 router_en;
  int                 grant_delay;
  int                 wait_cnt;
  int                 exp_cnt;

  injector_local_port_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .IDX_W    (IDX_W),
    .dataWidth(DW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ReqUp    (req_up),
    .PacketIn (packet_in),
    .GntUp    (gnt_up),
    .FullUp   (full_up),
    .ReqDnStr (req_dn),
    .GntDnStr (gnt_dn),
    .DnStrFull(dn_full),
    .PacketOut(packet_out),
    .PktCount (pkt_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic expectGrant(input int idx, input logic [31:0] pkt);
    exp_t e;
    e.idx = idx;
    e.pkt = pkt;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input int idx, input logic [31:0] pkt);
    req_up[idx] = 1'b1;
    packet_in[idx*DW +: DW] = pkt;
  endtask

  // One clock: sample at the falling edge, score grants, then let the router
  // and injector models react.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (prev_gnt != '0) begin
      checkOutput("gnt_one_cycle", 32'(gnt_up), 32'd0);
    end
    if (gnt_up != '0) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_gnt", 32'(gnt_up), 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("gnt_idx", 32'(gnt_up), 32'd1 << e.idx);
        checkOutput("gnt_pkt", packet_out, e.pkt);
        checkOutput("req_dn_after_gnt", 32'(req_dn), 32'd0);
      end
    end
    prev_gnt = gnt_up;
    if (gnt_dn) begin
      gnt_dn = 1'b0;
    end else if (router_en && req_dn) begin
      if (wait_cnt >= grant_delay) begin
        gnt_dn   = 1'b1;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (raise_next[i]) begin
        req_up[i]     = 1'b1;
        raise_next[i] = 1'b0;
      end else if (drop_next[i]) begin
        req_up[i]    = 1'b0;
        drop_next[i] = 1'b0;
        if (rereq[i] > 0) begin
          rereq[i]--;
          raise_next[i] = 1'b1;
        end
      end else if (gnt_up[i] && req_up[i]) begin
        drop_next[i] = 1'b1;
      end
    end
  endtask

  task automatic wait_quiet(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || req_up != '0 || raise_next != '0) && n < budget) begin
      tick();
      n++;
    end
    checkOutput("drain", 32'(sb.size()), 32'd0);
    tick();
    tick();
  endtask

  task automatic wait_req_dn(input int budget);
    int n;
    n = 0;
    while (!req_dn && n < budget) begin
      tick();
      n++;
    end
    checkOutput("req_dn_rise", 32'(req_dn), 32'd1);
  endtask

  task automatic clear_models();
    sb.delete();
    drop_next  = '0;
    raise_next = '0;
    prev_gnt   = '0;
    gnt_dn     = 1'b0;
    wait_cnt   = 0;
    for (int i = 0; i < NUM_REQ; i++) rereq[i] = 0;
  endtask

  initial begin
    reset       = 1'b0;
    req_up      = '0;
    packet_in   = '0;
    dn_full     = 1'b0;
    router_en   = 1'b1;
    grant_delay = 0;
    clear_models();
    tick();
    tick();
    checkOutput("rst_gnt", 32'(gnt_up), 32'd0);
    checkOutput("rst_req_dn", 32'(req_dn), 32'd0);
    checkOutput("rst_pkt", packet_out, 32'd0);
    checkOutput("rst_cnt", 32'(pkt_count), 32'd0);
    checkOutput("rst_full", 32'(full_up), 32'd0);
    reset = 1'b1;
    tick();

    $display("[TB] single injector, immediate router grant");
    expectGrant(0, 32'hA5A5_0001);
    applyStimulus(0, 32'hA5A5_0001);
    tick();
    checkOutput("t1_req_dn", 32'(req_dn), 32'd1);
    checkOutput("t1_pkt_out", packet_out, 32'hA5A5_0001);
    checkOutput("t1_full", 32'(full_up), 32'b1110);
    wait_quiet(50);
    expectGrant(1, 32'hB000_0001);
    expectGrant(0, 32'hB000_0000);
    applyStimulus(0, 32'hB000_0000);
    applyStimulus(1, 32'hB000_0001);
    wait_quiet(50);

    $display("[TB] all injectors requesting from reset release");
    reset = 1'b0;
    clear_models();
    tick();
    for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 32'hC000_0000 + 32'(i));
    rereq[0] = 1;
    expectGrant(0, 32'hC000_0000);
    expectGrant(1, 32'hC000_0001);
    expectGrant(2, 32'hC000_0002);
    expectGrant(3, 32'hC000_0003);
    expectGrant(0, 32'hC000_0000);
    reset = 1'b1;
    wait_quiet(100);
`ifdef ARB_PKT_COUNT_EN
    exp_cnt = 5;
`else
    exp_cnt = 0;
`endif
    checkOutput("t2_pkt_count", 32'(pkt_count), 32'(exp_cnt));

    $display("[TB] pointer at 3, injectors 0 and 3 competing");
    expectGrant(2, 32'hD000_0002);
    applyStimulus(2, 32'hD000_0002);
    wait_quiet(50);
    expectGrant(3, 32'hD000_0003);
    expectGrant(0, 32'hD000_0000);
    applyStimulus(0, 32'hD000_0000);
    applyStimulus(3, 32'hD000_0003);
    wait_quiet(50);

    $display("[TB] router full blocks arbitration");
    dn_full = 1'b1;
    expectGrant(1, 32'hE000_0001);
    applyStimulus(1, 32'hE000_0001);
    for (int c = 0; c < 10; c++) begin
      tick();
      checkOutput("t4_req_dn_blocked", 32'(req_dn), 32'd0);
      checkOutput("t4_full_all", 32'(full_up), 32'b1111);
    end
    dn_full = 1'b0;
    tick();
    checkOutput("t4_req_dn_release", 32'(req_dn), 32'd1);
    checkOutput("t4_pkt_out", packet_out, 32'hE000_0001);
    wait_quiet(50);

    $display("[TB] reset during router wait");
    router_en = 1'b0;
    applyStimulus(2, 32'hF000_0002);
    wait_req_dn(10);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t5_req_dn", 32'(req_dn), 32'd0);
    checkOutput("t5_gnt", 32'(gnt_up), 32'd0);
    checkOutput("t5_pkt_out", packet_out, 32'd0);
    checkOutput("t5_cnt", 32'(pkt_count), 32'd0);
    checkOutput("t5_full", 32'(full_up), 32'd0);
    clear_models();
    tick();
    applyStimulus(0, 32'hF000_0000);
    expectGrant(0, 32'hF000_0000);
    expectGrant(2, 32'hF000_0002);
    router_en = 1'b1;
    reset = 1'b1;
    wait_quiet(50);

    $display("[TB] slow router grant with a newcomer waiting");
    grant_delay = 7;
    expectGrant(0, 32'h1234_0000);
    applyStimulus(0, 32'h1234_0000);
    wait_req_dn(10);
    expectGrant(2, 32'h1234_0002);
    applyStimulus(2, 32'h1234_0002);
    for (int c = 0; c < 5; c++) begin
      tick();
      checkOutput("t6_pkt_stable", packet_out, 32'h1234_0000);
      checkOutput("t6_full2", 32'(full_up[2]), 32'd1);
      checkOutput("t6_no_gnt", 32'(gnt_up), 32'd0);
      checkOutput("t6_req_dn", 32'(req_dn), 32'd1);
    end
    wait_quiet(100);
    grant_delay = 0;

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/injector_local_port_arbiter.md
Name: injector_local_port_arbiter

Overview:
- Shares one router Local input port among NUM_REQ packet injectors (PEs) using round-robin arbitration.
- Sits between the injectors and the router's Local port.
- Upstream side: each injector sees the same Req/Gnt/Full handshake it would see from the router.
- Downstream side: the block presents a single requester to the router and forwards one 32-bit head flit per grant.

Parameters:
- NUM_REQ, 4: number of injectors; must be 2..8.
- IDX_W, 2: width of the winner index and RR pointer; must equal ceil(log2(NUM_REQ)).
- dataWidth, 32: packet width.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- ReqUp  input  NUM_REQ  per-injector request; held high until that injector sees its GntUp.
- PacketIn  input  NUM_REQ*dataWidth  flattened packets; slice i = [i*dataWidth +: dataWidth]. Stable while ReqUp[i] is high.
- GntUp  output  NUM_REQ  one-hot, one-cycle grant pulse back to the winning injector.
- FullUp  output  NUM_REQ  per-injector full indication (combinational).
- ReqDnStr  output  1  request to the router Local port.
- GntDnStr  input  1  grant from the router.
- DnStrFull  input  1  router Local FIFO full.
- PacketOut  output  dataWidth  registered packet to the router.
- PktCount  output  16  forwarded-packet count; see Optional Feature.

Behaviour:
- Reset (asynchronous, while reset=0):
  - state=IDLE, ptr=0, winner=0.
  - GntUp=0, ReqDnStr=0, PacketOut=0, PktCount=0.
  - Applies mid-transaction too; an in-flight packet is dropped with no GntUp.
- FullUp[i] = DnStrFull | (state!=IDLE & winner!=i). Purely combinational.
- FSM, all registered on posedge clk:
  - IDLE:
    - Advances only if |ReqUp and !DnStrFull.
    - winner = first i with ReqUp[i]=1, searching ptr, ptr+1, … modulo NUM_REQ.
    - Latch PacketOut <= PacketIn slice[winner], set ReqDnStr <= 1, go to WAIT_GNT.
    - If DnStrFull=1, stay in IDLE with no output change.
  - WAIT_GNT:
    - ReqDnStr stays high and PacketOut is frozen.
    - On GntDnStr=1: ReqDnStr <= 0, GntUp[winner] <= 1, ptr <= (winner+1) mod NUM_REQ, PktCount++ (when enabled), go to RELEASE.
    - New ReqUp activity is ignored in this state.
  - RELEASE:
    - GntUp <= 0 unconditionally on the first cycle.
    - Stay until ReqUp[winner]=0, then go to IDLE.
    - Other requesters keep waiting.
- GntDnStr outside WAIT_GNT: ignored.
- Latency:
  - ReqUp sampled high at edge E0 (IDLE) -> ReqDnStr high after E0.
  - GntDnStr sampled at E1 -> GntUp pulse high for exactly one cycle after E1.
  - With an injector that drops Req one edge after seeing Gnt, the arbiter is back in IDLE after E3.
  - Minimum 4 cycles per packet.
- Simultaneous events:
  - ReqUp rising in the same cycle as a RELEASE->IDLE transition is arbitrated on the next IDLE edge.
  - The winner's own re-request is allowed only after it has dropped ReqUp.
- Pointer rules:
  - ptr wraps from NUM_REQ-1 to 0.
  - With NUM_REQ not a power of two, ptr never takes values >= NUM_REQ.
- PacketOut is unchanged except at the IDLE->WAIT_GNT latch.

Optional Feature:
- Macro: ARB_PKT_COUNT_EN.
- Defined:
  - PktCount is a 16-bit register, incremented on each WAIT_GNT->RELEASE transition.
  - Wraps 65535->0.
  - Reset to 0.
- Undefined:
  - PktCount is tied to constant 0.
  - No counter logic is synthesized.

Test Plan:
1. Only ReqUp=4'b0001, PacketIn[0]=32'hA5A5_0001; router grants 1 cycle after ReqDnStr -> PacketOut=32'hA5A5_0001 while ReqDnStr=1; GntUp=4'b0001 for exactly one cycle; ptr becomes 1.
2. All four ReqUp held from reset release, router grants immediately each time -> grant order 0,1,2,3,0; PktCount=5 (with macro).
3. ptr=3 after serving injector 2; ReqUp=4'b1001 -> injector 3 wins, then injector 0; injector 0 is not starved.
4. DnStrFull=1 with ReqUp=4'b0010 for 10 cycles -> ReqDnStr stays 0 and FullUp=4'b1111; DnStrFull drops -> ReqDnStr rises next edge.
5. reset asserted low while in WAIT_GNT -> ReqDnStr, GntUp, PacketOut and PktCount go to 0 immediately; after release, arbitration restarts at injector 0.
6. Router delays GntDnStr 7 cycles; injector 2 asserts ReqUp meanwhile -> PacketOut stable, FullUp[2]=1, no GntUp until GntDnStr; injector 2 is served next.
